// File: rtl/eacsu_322.sv
// eacsu_322: 8-state, radix-4 add-compare-select unit with path-metric
// normalisation and a one-cycle-delayed best-state search.
module eacsu_322 #(
  parameter int PMW     = 6,
  parameter int INIT_PM = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] hd,
  input  logic        en,
  input  logic        init,
  output logic [15:0] dec,
  output logic        dec_valid,
  output logic [2:0]  best_state,
  output logic        best_valid,
  output logic        norm
);

  localparam logic [PMW-1:0] INIT_V = PMW'(INIT_PM);
  localparam logic [PMW-1:0] SAT_V  = '1;
  localparam logic [PMW-1:0] MSB_M  = {1'b1, {(PMW-1){1'b0}}};

  logic [PMW-1:0] pm_q [8];
  logic [PMW-1:0] pm_d [8];
  logic [15:0]    dec_q, dec_d;
  logic           dec_valid_q, dec_valid_d;
  logic           norm_q, norm_d;
  logic [2:0]     best_state_q, best_state_d;
  logic           best_valid_q, best_valid_d;

  logic [PMW:0]   sum_w [8][4];
  logic [PMW-1:0] cand [8][4];
  logic [PMW-1:0] step_pm [8];
  logic [PMW-1:0] store_pm [8];
  logic [15:0]    step_dec;
  logic           step_all_high;

  logic [PMW-1:0] min_pm;
  logic [2:0]     min_idx;

  // Add-compare-select for all 8 states, then optional MSB normalisation.
  // Predecessor of (s, j) is {j, s[2]}; branch metric is HD(4s+j+1).
  always_comb begin
    step_dec      = '0;
    step_all_high = 1'b1;
    for (int s = 0; s < 8; s++) begin
      for (int j = 0; j < 4; j++) begin
        sum_w[s][j] = {1'b0, pm_q[3'(j * 2 + s / 4)]}
                    + {{(PMW-1){1'b0}}, hd[8 * s + 2 * j +: 2]};
        cand[s][j]  = sum_w[s][j][PMW] ? SAT_V : sum_w[s][j][PMW-1:0];
      end
    end
    for (int s = 0; s < 8; s++) begin
      step_pm[s] = cand[s][0];
      // strict less-than keeps the lowest j on ties
      for (int j = 1; j < 4; j++) begin
        if (cand[s][j] < step_pm[s]) begin
          step_pm[s]           = cand[s][j];
          step_dec[2 * s +: 2] = 2'(j);
        end
      end
      if (!step_pm[s][PMW-1]) step_all_high = 1'b0;
    end
    for (int s = 0; s < 8; s++) begin
      store_pm[s] = step_all_high ? (step_pm[s] & ~MSB_M) : step_pm[s];
    end
  end

  // Minimum search over the stored metrics; lowest index wins ties.
  always_comb begin
    min_pm  = pm_q[0];
    min_idx = 3'd0;
    for (int s = 1; s < 8; s++) begin
      if (pm_q[s] < min_pm) begin
        min_pm  = pm_q[s];
        min_idx = 3'(s);
      end
    end
  end

  // Next-state selection: init beats en; the best stage trails dec_valid by one cycle.
  always_comb begin
    pm_d         = pm_q;
    dec_d        = dec_q;
    dec_valid_d  = 1'b0;
    norm_d       = 1'b0;
    best_state_d = best_state_q;
    best_valid_d = 1'b0;
    if (init) begin
      pm_d[0] = '0;
      for (int s = 1; s < 8; s++) pm_d[s] = INIT_V;
    end else begin
      best_valid_d = dec_valid_q;
      if (dec_valid_q) best_state_d = min_idx;
      if (en) begin
        pm_d        = store_pm;
        dec_d       = step_dec;
        dec_valid_d = 1'b1;
        norm_d      = step_all_high;
      end
    end
  end

  // State registers with asynchronous reset to the init metrics.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pm_q[0] <= '0;
      for (int s = 1; s < 8; s++) pm_q[s] <= INIT_V;
      dec_q        <= '0;
      dec_valid_q  <= 1'b0;
      norm_q       <= 1'b0;
      best_state_q <= '0;
      best_valid_q <= 1'b0;
    end else begin
      pm_q         <= pm_d;
      dec_q        <= dec_d;
      dec_valid_q  <= dec_valid_d;
      norm_q       <= norm_d;
      best_state_q <= best_state_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign dec        = dec_q;
  assign dec_valid  = dec_valid_q;
  assign norm       = norm_q;
  assign best_state = best_state_q;
  assign best_valid = best_valid_q;

endmodule

// File: tb/tb_eacsu_322.sv
// Testbench for eacsu_322: directed and random steps against a behavioural model.
module tb_eacsu_322;

  localparam int PMW     = 6;
  localparam int INIT_PM = 16;
  localparam int SAT     = (1 << PMW) - 1;
  localparam int HALF    = 1 << (PMW - 1);

  logic        clock;
  logic        reset;
  logic [63:0] hd;
  logic        en;
  logic        init;
  logic [15:0] dec;
  logic        dec_valid;
  logic [2:0]  best_state;
  logic        best_valid;
  logic        norm;

  eacsu_322 #(.PMW(PMW), .INIT_PM(INIT_PM)) dut (
    .clock(clock), .reset(reset), .hd(hd), .en(en), .init(init),
    .dec(dec), .dec_valid(dec_valid), .best_state(best_state),
    .best_valid(best_valid), .norm(norm)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  // reference model state: saturating/normalising metrics and unbounded metrics
  int          m_pm [8];
  int          w_pm [8];
  logic [15:0] m_dec, w_dec;
  logic        m_dv, m_norm, m_bv;
  logic [2:0]  m_bs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  function automatic int hd_of(input logic [63:0] h, input int k);
    return int'((h >> (2 * k - 2)) & 64'd3);
  endfunction

  function automatic logic [63:0] hd_all(input int v);
    logic [63:0] h;
    h = '0;
    for (int k = 0; k < 32; k++) h[2 * k +: 2] = 2'(v);
    return h;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 8; s++) begin
      m_pm[s] = (s == 0) ? 0 : INIT_PM;
      w_pm[s] = m_pm[s];
    end
    m_dec = '0; w_dec = '0;
    m_dv = 1'b0; m_norm = 1'b0; m_bv = 1'b0; m_bs = '0;
  endfunction

  function automatic logic [2:0] argmin(input int a [8]);
    int b;
    b = 0;
    for (int s = 1; s < 8; s++) if (a[s] < a[b]) b = s;
    return 3'(b);
  endfunction

  function automatic void model_step(input logic e, input logic i, input logic [63:0] h);
    int np [8];
    int nw [8];
    int c, cw, bj, bjw;
    logic all_hi;
    if (i) m_bv = 1'b0;
    else begin
      m_bv = m_dv;
      if (m_dv) m_bs = argmin(m_pm);
    end
    if (i) begin
      for (int s = 0; s < 8; s++) begin
        m_pm[s] = (s == 0) ? 0 : INIT_PM;
        w_pm[s] = m_pm[s];
      end
      m_dv = 1'b0; m_norm = 1'b0;
    end else if (e) begin
      all_hi = 1'b1;
      for (int s = 0; s < 8; s++) begin
        np[s] = SAT + 1; nw[s] = 1 << 30; bj = 0; bjw = 0;
        for (int j = 0; j < 4; j++) begin
          c  = m_pm[j * 2 + s / 4] + hd_of(h, 4 * s + j + 1);
          cw = w_pm[j * 2 + s / 4] + hd_of(h, 4 * s + j + 1);
          if (c > SAT) c = SAT;
          if (c < np[s]) begin np[s] = c; bj = j; end
          if (cw < nw[s]) begin nw[s] = cw; bjw = j; end
        end
        m_dec[2 * s +: 2] = 2'(bj);
        w_dec[2 * s +: 2] = 2'(bjw);
        if (np[s] < HALF) all_hi = 1'b0;
      end
      for (int s = 0; s < 8; s++) begin
        m_pm[s] = all_hi ? np[s] - HALF : np[s];
        w_pm[s] = nw[s];
      end
      m_dv = 1'b1; m_norm = all_hi;
    end else begin
      m_dv = 1'b0; m_norm = 1'b0;
    end
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".dec_valid"}, 32'(dec_valid), 32'(m_dv));
    check({tag, ".dec"}, 32'(dec), 32'(m_dec));
    check({tag, ".norm"}, 32'(norm), 32'(m_norm));
    check({tag, ".best_valid"}, 32'(best_valid), 32'(m_bv));
    check({tag, ".best_state"}, 32'(best_state), 32'(m_bs));
  endtask

  task automatic cyc(input logic e, input logic i, input logic [63:0] h, input string tag);
    @(negedge clock);
    en = e; init = i; hd = h;
    @(posedge clock);
    model_step(e, i, h);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b1; en = 1'b0; init = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clock);
    reset = 1'b0;
  endtask

  int          dv_count;
  int          norm_count;
  logic [15:0] held_dec;
  logic [63:0] h;

  initial begin
    reset = 1'b1; en = 1'b0; init = 1'b0; hd = '0;
    model_reset();
    #2;
    check_outputs("reset0");
    @(negedge clock);
    reset = 1'b0;

    // all-zero branch metrics from reset
    cyc(1'b1, 1'b0, 64'd0, "zero_step");
    cyc(1'b0, 1'b0, 64'd0, "zero_best");
    check("zero_best_state", 32'(best_state), 32'd0);
    check("zero_best_valid", 32'(best_valid), 32'd1);

    // HD(1)=2, HD(2)=0, rest 3: state 0 picks j=0 with metric 2
    do_reset("reset1");
    h = hd_all(3);
    h[1:0] = 2'd2;
    h[3:2] = 2'd0;
    cyc(1'b1, 1'b0, h, "hd1_step");
    check("hd1_dec0", 32'(dec[1:0]), 32'd0);
    cyc(1'b0, 1'b0, 64'd0, "hd1_best");
    check("hd1_pm0", 32'(m_pm[0]), 32'd2);

    // tie handling: all metrics equal to 1
    do_reset("reset2");
    cyc(1'b1, 1'b0, hd_all(1), "tie_step");
    check("tie_dec", 32'(dec), 32'd0);
    cyc(1'b0, 1'b0, 64'd0, "tie_best");
    check("tie_best_state", 32'(best_state), 32'd0);

    // normalisation: keep adding 3 until every metric crosses the half range
    do_reset("reset3");
    norm_count = 0;
    for (int n = 0; n < 14; n++) begin
      cyc(1'b1, 1'b0, hd_all(3), "norm_step");
      check("norm_vs_wide", 32'(dec), 32'(w_dec));
      if (norm) norm_count++;
    end
    check("norm_count", 32'(norm_count), 32'd1);

    // idle gaps of five cycles between random steps
    dv_count = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, {$urandom, $urandom}, "gap_step");
      if (dec_valid) dv_count++;
      held_dec = dec;
      for (int g = 0; g < 5; g++) begin
        cyc(1'b0, 1'b0, {$urandom, $urandom}, "gap_idle");
        check("gap_dec_hold", 32'(dec), 32'(held_dec));
        if (dec_valid) dv_count++;
      end
    end
    check("gap_dv_count", 32'(dv_count), 32'd3);

    // init together with en in the middle of a stream
    cyc(1'b1, 1'b0, {$urandom, $urandom}, "init_pre");
    cyc(1'b1, 1'b1, {$urandom, $urandom}, "init_hit");
    check("init_dv", 32'(dec_valid), 32'd0);
    cyc(1'b0, 1'b0, 64'd0, "init_after");
    check("init_bv", 32'(best_valid), 32'd0);
    cyc(1'b1, 1'b0, 64'd0, "init_zero");
    check("init_zero_dec", 32'(dec), 32'd0);

    // random back-to-back stream with occasional idles and inits
    for (int n = 0; n < 300; n++) begin
      cyc(($urandom % 4) != 0, ($urandom % 32) == 0, {$urandom, $urandom}, "rand");
    end

    // reset in the middle of a busy stream leaves no valid pulse behind
    cyc(1'b1, 1'b0, {$urandom, $urandom}, "mid_step");
    do_reset("mid_reset");
    cyc(1'b0, 1'b0, 64'd0, "mid_after");
    check("mid_bv", 32'(best_valid), 32'd0);
    for (int n = 0; n < 50; n++) begin
      cyc(1'b1, 1'b0, {$urandom, $urandom}, "post_rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
